// File: rtl/hub75_pattern_feeder.sv
// HUB75 framebuffer test-pattern writer: fills each panel row pixel by pixel,
// handshakes row and frame buffer swaps with the downstream scan-out logic.
//
// state      | meaning
// WAIT_FRAME | idle, waiting for frame_rdy; latches cfg_mode on exit
// WRITE      | one pixel per cycle, col 0..N_COLS-1
// STORE      | one-cycle row_store pulse
// WAIT_ROW   | waiting for fbw_row_rdy (unbounded)
// ROW_SWAP   | one-cycle row_swap pulse, advance row or end frame
// FRAME_SWAP | one-cycle frame_swap pulse, bump frame counter
module hub75_pattern_feeder #(
  parameter int N_BANKS  = 2,
  parameter int N_ROWS   = 32,
  parameter int N_COLS   = 64,
  parameter int N_CHANS  = 3,
  parameter int N_PLANES = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [1:0]                                cfg_mode,
  output logic [$clog2(N_BANKS)+$clog2(N_ROWS)-1:0] fbw_row_addr,
  output logic                                      fbw_row_store,
  input  logic                                      fbw_row_rdy,
  output logic                                      fbw_row_swap,
  output logic [N_CHANS*N_PLANES-1:0]               fbw_data,
  output logic [$clog2(N_COLS)-1:0]                 fbw_col_addr,
  output logic                                      fbw_wren,
  output logic                                      frame_swap,
  input  logic                                      frame_rdy
);

  localparam int CW = $clog2(N_COLS);
  localparam int RW = $clog2(N_BANKS) + $clog2(N_ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_BANKS * N_ROWS - 1);

  typedef enum logic [2:0] {
    WAIT_FRAME,
    WRITE,
    STORE,
    WAIT_ROW,
    ROW_SWAP,
    FRAME_SWAP
  } state_t;

  state_t      state_q, state_d;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [7:0]    frame_q;
  logic [1:0]    mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_FRAME;
      row_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        WAIT_FRAME: begin
          if (frame_rdy) begin
            mode_q <= cfg_mode;
            row_q  <= '0;
            col_q  <= '0;
          end
        end
        WRITE:      col_q <= col_q + CW'(1);
        ROW_SWAP: begin
          if (row_q != ROW_LAST) begin
            row_q <= row_q + RW'(1);
            col_q <= '0;
          end
        end
        FRAME_SWAP: frame_q <= frame_q + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    fbw_wren      = 1'b0;
    fbw_row_store = 1'b0;
    fbw_row_swap  = 1'b0;
    frame_swap    = 1'b0;
    case (state_q)
      WAIT_FRAME: if (frame_rdy) state_d = WRITE;
      WRITE: begin
        fbw_wren = 1'b1;
        if (col_q == COL_LAST) state_d = STORE;
      end
      STORE: begin
        fbw_row_store = 1'b1;
        state_d       = WAIT_ROW;
      end
      WAIT_ROW: if (fbw_row_rdy) state_d = ROW_SWAP;
      ROW_SWAP: begin
        fbw_row_swap = 1'b1;
        state_d      = (row_q == ROW_LAST) ? FRAME_SWAP : WRITE;
      end
      FRAME_SWAP: begin
        frame_swap = 1'b1;
        state_d    = WAIT_FRAME;
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  // Gradient scales the counters to the full 8-bit range for any power-of-2 size.
  logic [7:0]                  r_grad, g_grad;
  logic [2:0]                  bar;
  logic                        chk;
  logic [N_CHANS*N_PLANES-1:0] pixel;

  always_comb begin
    r_grad = 8'({col_q, 8'h00} >> CW);
    g_grad = 8'({row_q, 8'h00} >> RW);
    bar    = col_q[CW-1 -: 3];
    chk    = col_q[3] ^ row_q[3];
    case (mode_q)
      2'd0:    pixel = {r_grad, g_grad, frame_q};
      2'd1:    pixel = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      2'd2:    pixel = '1;
      default: pixel = {24{chk}};
    endcase
  end

  assign fbw_row_addr = row_q;
  assign fbw_col_addr = col_q;
  assign fbw_data     = (state_q == WRITE) ? pixel : '0;

endmodule

// File: tb/tb_hub75_pattern_feeder.sv
// Scoreboard bench for hub75_pattern_feeder: stimulus queues the expected
// write/pulse stream per frame, a negedge monitor pops and compares.
module tb_hub75_pattern_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        fbw_row_rdy = 1'b0;
  logic        frame_rdy = 1'b0;
  logic [5:0]  fbw_row_addr;
  logic        fbw_row_store;
  logic        fbw_row_swap;
  logic [23:0] fbw_data;
  logic [5:0]  fbw_col_addr;
  logic        fbw_wren;
  logic        frame_swap;

  hub75_pattern_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_mode     (cfg_mode),
    .fbw_row_addr (fbw_row_addr),
    .fbw_row_store(fbw_row_store),
    .fbw_row_rdy  (fbw_row_rdy),
    .fbw_row_swap (fbw_row_swap),
    .fbw_data     (fbw_data),
    .fbw_col_addr (fbw_col_addr),
    .fbw_wren     (fbw_wren),
    .frame_swap   (frame_swap),
    .frame_rdy    (frame_rdy)
  );

  always #5 clk = ~clk;

  // kind: 0 wren, 1 row_store, 2 row_swap, 3 frame_swap; dt 0 = spacing unchecked
  typedef struct {
    int          kind;
    int          row;
    int          col;
    logic [23:0] data;
    int          dt;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last_cyc = 0;

  always @(posedge clk) cyc++;

  function automatic logic [23:0] exp_pix(input int mode, input int row, input int col, input int frame);
    int b;
    case (mode)
      0: return {8'((col * 4) % 256), 8'((row * 4) % 256), 8'(frame % 256)};
      1: begin
        b = col / 8;
        return {((b & 4) != 0) ? 8'hFF : 8'h00,
                ((b & 2) != 0) ? 8'hFF : 8'h00,
                ((b & 1) != 0) ? 8'hFF : 8'h00};
      end
      2: return 24'hFFFFFF;
      default: return ((((col / 8) % 2) ^ ((row / 8) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic push(input int kind, input int row, input int col, input logic [23:0] data, input int dt);
    ev_t e;
    e.kind = kind; e.row = row; e.col = col; e.data = data; e.dt = dt;
    q.push_back(e);
  endtask

  // stop_row/stop_col truncate the stream for the mid-frame reset case
  task automatic push_frame(input int mode, input int frame, input bit hold0, input int stop_row, input int stop_col);
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        if (r == stop_row && c > stop_col) return;
        push(0, r, c, exp_pix(mode, r, c, frame), (c == 0) ? ((r == 0) ? 0 : 1) : 1);
      end
      push(1, r, 0, 24'h0, 1);
      push(2, r, 0, 24'h0, (hold0 && r == 0) ? 0 : 2);
    end
    push(3, 63, 0, 24'h0, 1);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic wait_ev(input int kind, input int r, input int c, input int limit, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (kind)
        0:       hit = fbw_row_store;
        1:       hit = frame_swap;
        default: hit = fbw_wren && (int'(fbw_row_addr) == r) && (int'(fbw_col_addr) == c);
      endcase
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s no event within %0d cycles", name, limit);
      finish_run();
    end
  endtask

  task automatic run_frame(input string name);
    frame_rdy = 1'b1;
    wait_ev(1, 0, 0, 5000, name);
    frame_rdy = 1'b0;
    @(posedge clk);
    check({name, "_drain"}, q.size(), 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    int  n, k, got_dt;
    ev_t e;
    bit  ok;
    if (rst) begin
      n = int'(fbw_wren) + int'(fbw_row_store) + int'(fbw_row_swap) + int'(frame_swap);
      if (n > 1) begin
        tests++;
        fails++;
        $display("FAIL multi_pulse wren=%0b store=%0b rswap=%0b fswap=%0b expected one at most",
                 fbw_wren, fbw_row_store, fbw_row_swap, frame_swap);
      end else if (n == 1) begin
        k = fbw_wren ? 0 : fbw_row_store ? 1 : fbw_row_swap ? 2 : 3;
        got_dt = cyc - last_cyc;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output kind=%0d row=%0d col=%0d expected no output",
                   k, fbw_row_addr, fbw_col_addr);
        end else begin
          e = q.pop_front();
          ok = (e.kind == k) && (int'(fbw_row_addr) == e.row) &&
               ((k != 0) || ((int'(fbw_col_addr) == e.col) && (fbw_data === e.data))) &&
               ((e.dt == 0) || (got_dt == e.dt));
          if (!ok) begin
            fails++;
            $display("FAIL scoreboard got kind=%0d row=%0d col=%0d data=%06h dt=%0d expected kind=%0d row=%0d col=%0d data=%06h dt=%0d",
                     k, fbw_row_addr, fbw_col_addr, fbw_data, got_dt, e.kind, e.row, e.col, e.data, e.dt);
          end
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #(10 * 100000);
    tests++;
    fails++;
    $display("FAIL watchdog simulation time limit reached");
    finish_run();
  end

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {fbw_wren, fbw_row_store, fbw_row_swap, frame_swap, fbw_data},
          32'h0);
    check("reset_addr", {fbw_row_addr, fbw_col_addr}, 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Frame 0, gradient, downstream always ready
    cfg_mode = 2'd0;
    fbw_row_rdy = 1'b1;
    push_frame(0, 0, 1'b0, -1, 0);
    run_frame("frame0_grad");

    // Frame 1, gradient, row ready held off after the first row_store
    fbw_row_rdy = 1'b0;
    push_frame(0, 1, 1'b1, -1, 0);
    frame_rdy = 1'b1;
    wait_ev(0, 0, 0, 200, "first_store");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fbw_wren || fbw_row_swap || frame_swap) bad++;
    end
    check("row_hold_quiet", bad, 0);
    fbw_row_rdy = 1'b1;
    @(negedge clk);
    check("row_swap_latency", fbw_row_swap, 1);
    wait_ev(1, 0, 0, 5000, "frame1_grad");
    frame_rdy = 1'b0;
    @(posedge clk);
    check("frame1_grad_drain", q.size(), 0);

    // Frame 2, colour bars
    cfg_mode = 2'd1;
    push_frame(1, 2, 1'b0, -1, 0);
    run_frame("frame2_bars");

    // Frame 3, solid; mode switched to checker mid-frame must not apply yet
    cfg_mode = 2'd2;
    push_frame(2, 3, 1'b0, -1, 0);
    frame_rdy = 1'b1;
    wait_ev(2, 10, 0, 2000, "row10");
    cfg_mode = 2'd3;
    wait_ev(1, 0, 0, 5000, "frame3_solid");
    frame_rdy = 1'b0;
    @(posedge clk);
    check("frame3_solid_drain", q.size(), 0);

    // Frame 4, checker picked up at frame start
    push_frame(3, 4, 1'b0, -1, 0);
    run_frame("frame4_checker");

    // Frame 5, aborted by reset at row 7 col 30
    cfg_mode = 2'd0;
    push_frame(0, 5, 1'b0, 7, 30);
    frame_rdy = 1'b1;
    wait_ev(2, 7, 30, 1000, "row7_col30");
    frame_rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("abort_outputs",
          {fbw_wren, fbw_row_store, fbw_row_swap, frame_swap, fbw_data},
          32'h0);
    check("abort_queue", q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fbw_wren || fbw_row_store || fbw_row_swap || frame_swap) bad++;
    end
    check("post_reset_quiet", bad, 0);

    // Frame counter restarts at 0; first write must be row 0 col 0
    push_frame(0, 0, 1'b0, -1, 0);
    run_frame("frame_after_reset");

    finish_run();
  end

endmodule
